lc3_kbd_uart_rx: RTL and testbench

//  Serial-input counterpart of the display UART transmitter: receives 8N1 UART bytes and presents them
//  to the LC-3 as the memory-mapped keyboard pair KBSR/KBDR. Sits between the board RX pin and the
//  LC-3 memory-mapped I/O decode. Provides a ready flag, an optional interrupt request, and

---
 rtl/lc3_io_pkg.sv | 16 +
 rtl/uart_rx_core.sv | 70 +++++++
 rtl/lc3_kbd_uart_rx.sv | 59 +++++
 tb/tb_lc3_kbd_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_io_pkg.sv
// lc3_io_pkg: LC-3 memory-mapped I/O constants and RX FSM encoding shared by keyboard and display sides
package lc3_io_pkg;
  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } rx_state_t;
  localparam int KBSR_RDY = 15;
  localparam int KBSR_IE  = 14;
  localparam int KBSR_FE  = 13;
  localparam int KBSR_OVR = 12;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with input synchroniser, reporting each finished frame for one cycle
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);
  import lc3_io_pkg::*;
  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  rx_state_t  state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic       rx_m, rx_s, rx_p;
  // two-flop synchroniser plus a delayed copy so IDLE only starts on a falling edge
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= i_Rx_Serial;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  // frame FSM: mid-bit sampling, LSB-first shift, frame result flagged during CLEANUP
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      idx       <= '0;
      rx_byte   <= '0;
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (rx_p && !rx_s) state <= RX_START;
        end
        RX_START:
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 8'd1;
        RX_DATA:
          if (cnt == LAST) begin
            cnt          <= '0;
            rx_byte[idx] <= rx_s;
            idx          <= idx + 3'd1;
            if (idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 8'd1;
        RX_STOP:
          if (cnt == LAST) begin
            cnt       <= '0;
            byte_ok   <= rx_s;
            frame_err <= !rx_s;
            state     <= RX_CLEANUP;
          end else cnt <= cnt + 8'd1;
        default: state <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/lc3_kbd_uart_rx.sv
// lc3_kbd_uart_rx: UART receiver presented to the LC-3 as the KBSR/KBDR keyboard register pair
module lc3_kbd_uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        i_Clock,
  input  logic        i_Rst_n,
  input  logic        i_Rx_Serial,
  input  logic        i_KBDR_Rd,
  input  logic        i_KBSR_Wr,
  input  logic [15:0] i_KBSR_Wdata,
  output logic [15:0] o_KBSR,
  output logic [15:0] o_KBDR,
  output logic        o_Rx_DV,
  output logic        o_Kbd_Int
);
  import lc3_io_pkg::*;
  logic [7:0] rx_byte, kbdr;
  logic       byte_ok, frame_err, load;
  logic       rdy, ie, fe, ovr;
  logic       unused_wdata;
  assign unused_wdata = ^{i_KBSR_Wdata[15], i_KBSR_Wdata[13:0]};
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_Rx_Serial(i_Rx_Serial),
    .rx_byte    (rx_byte),
    .byte_ok    (byte_ok),
    .frame_err  (frame_err)
  );
  assign load   = byte_ok & (~rdy | i_KBDR_Rd);
  assign o_KBDR = {8'h00, kbdr};
  // status word assembled from the individual flag registers
  always_comb begin
    o_KBSR           = '0;
    o_KBSR[KBSR_RDY] = rdy;
    o_KBSR[KBSR_IE]  = ie;
    o_KBSR[KBSR_FE]  = fe;
    o_KBSR[KBSR_OVR] = ovr;
  end
  // a read clears all status unless a new byte lands in the same cycle; a write only touches IE
  always_ff @(posedge i_Clock or negedge i_Rst_n)
    if (!i_Rst_n) begin
      rdy       <= 1'b0;
      ie        <= 1'b0;
      fe        <= 1'b0;
      ovr       <= 1'b0;
      kbdr      <= '0;
      o_Rx_DV   <= 1'b0;
      o_Kbd_Int <= 1'b0;
    end else begin
      o_Rx_DV   <= load;
      o_Kbd_Int <= rdy & ie;
      if (i_KBSR_Wr) ie <= i_KBSR_Wdata[KBSR_IE];
      if (load) kbdr <= rx_byte;
      rdy <= load | (rdy & ~i_KBDR_Rd);
      fe  <= frame_err | (fe & ~i_KBDR_Rd);
      ovr <= (byte_ok & ~load) | (ovr & ~i_KBDR_Rd);
    end
endmodule

// File: tb/tb_lc3_kbd_uart_rx.sv
// tb_lc3_kbd_uart_rx: table, hand sequences and random frames against a register-level model
module tb_lc3_kbd_uart_rx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] wdata = '0;
  logic        rxl [3];
  logic [15:0] kbsr [3];
  logic [15:0] kbdr [3];
  logic        dv [3];
  logic        kint [3];
  int checks = 0, errors = 0;
  int sel = 1, cyc = 0, dvcnt = 0, rdy_cyc = -1, int_cyc = -1;
  logic m_rdy, m_ie, m_fe, m_ovr;
  logic [7:0] m_kbdr;

  always #5 clk = ~clk;

  lc3_kbd_uart_rx #(.CLKS_PER_BIT(4)) u4 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rxl[0]), .i_KBDR_Rd(rd), .i_KBSR_Wr(wr),
    .i_KBSR_Wdata(wdata), .o_KBSR(kbsr[0]), .o_KBDR(kbdr[0]), .o_Rx_DV(dv[0]), .o_Kbd_Int(kint[0]));
  lc3_kbd_uart_rx #(.CLKS_PER_BIT(16)) u16 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rxl[1]), .i_KBDR_Rd(rd), .i_KBSR_Wr(wr),
    .i_KBSR_Wdata(wdata), .o_KBSR(kbsr[1]), .o_KBDR(kbdr[1]), .o_Rx_DV(dv[1]), .o_Kbd_Int(kint[1]));
  lc3_kbd_uart_rx #(.CLKS_PER_BIT(255)) u255 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rxl[2]), .i_KBDR_Rd(rd), .i_KBSR_Wr(wr),
    .i_KBSR_Wdata(wdata), .o_KBSR(kbsr[2]), .o_KBDR(kbdr[2]), .o_Rx_DV(dv[2]), .o_Kbd_Int(kint[2]));

  function automatic int cpb(input int s);
    return s == 0 ? 4 : s == 1 ? 16 : 255;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (dv[sel]) dvcnt++;
      if (kbsr[sel][15] && rdy_cyc < 0) rdy_cyc = cyc;
      if (kint[sel] && int_cyc < 0) int_cyc = cyc;
    end
  endtask

  // whole 8N1 frame plus a tail long enough for CLEANUP; rdc is the frame cycle carrying a read strobe
  task automatic send(input logic [7:0] b, input logic stop, input int rdc);
    int c, h;
    c = cpb(sel);
    h = (c - 1) / 2;
    dvcnt = 0;
    rdy_cyc = -1;
    int_cyc = -1;
    for (int n = 0; n < 10 * c + h + 8; n++) begin
      rxl[sel] = n < c ? 1'b0 : n < 9 * c ? b[n / c - 1] : n < 10 * c ? stop : 1'b1;
      rd = (n == rdc);
      tick(1);
    end
    rd = 1'b0;
  endtask

  function automatic int cleanup_cyc();
    return 4 + (cpb(sel) - 1) / 2 + 9 * cpb(sel);
  endfunction

  task automatic do_read();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] d);
    wr = 1'b1;
    wdata = d;
    tick(1);
    wr = 1'b0;
  endtask

  typedef struct {
    int          op;
    logic [15:0] d;
    logic        stop;
    logic        rdin;
    logic [15:0] ks;
    logic [15:0] kd;
    int          dv;
    logic        it;
  } vec_t;
  vec_t tbl [15];

  initial begin
    tbl[0]  = '{0, 16'h0041, 1'b1, 1'b0, 16'h8000, 16'h0041, 1, 1'b0};
    tbl[1]  = '{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0041, 0, 1'b0};
    tbl[2]  = '{0, 16'h0055, 1'b0, 1'b0, 16'h2000, 16'h0041, 0, 1'b0};
    tbl[3]  = '{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0041, 0, 1'b0};
    tbl[4]  = '{0, 16'h0031, 1'b1, 1'b0, 16'h8000, 16'h0031, 1, 1'b0};
    tbl[5]  = '{0, 16'h0032, 1'b1, 1'b0, 16'h9000, 16'h0031, 0, 1'b0};
    tbl[6]  = '{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0031, 0, 1'b0};
    tbl[7]  = '{0, 16'h0031, 1'b1, 1'b0, 16'h8000, 16'h0031, 1, 1'b0};
    tbl[8]  = '{0, 16'h0032, 1'b1, 1'b1, 16'h8000, 16'h0032, 1, 1'b0};
    tbl[9]  = '{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0032, 0, 1'b0};
    tbl[10] = '{2, 16'h4000, 1'b1, 1'b0, 16'h4000, 16'h0032, 0, 1'b0};
    tbl[11] = '{0, 16'h000D, 1'b1, 1'b0, 16'hC000, 16'h000D, 1, 1'b1};
    tbl[12] = '{2, 16'hFFFF, 1'b1, 1'b0, 16'hC000, 16'h000D, 0, 1'b1};
    tbl[13] = '{2, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h000D, 0, 1'b0};
    tbl[14] = '{1, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h000D, 0, 1'b0};
    for (int s = 0; s < 3; s++) rxl[s] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset kbsr%0d", s), kbsr[s], 16'h0000);
      chk($sformatf("reset kbdr%0d", s), kbdr[s], 16'h0000);
      chk($sformatf("reset dv_int%0d", s), {14'b0, dv[s], kint[s]}, 16'h0000);
    end
    sel = 1;
    for (int i = 0; i < 15; i++) begin
      dvcnt = 0;
      case (tbl[i].op)
        0: send(tbl[i].d[7:0], tbl[i].stop, tbl[i].rdin ? cleanup_cyc() : -1);
        1: do_read();
        default: do_write(tbl[i].d);
      endcase
      tick(2);
      chk($sformatf("v%0d kbsr", i), kbsr[sel], tbl[i].ks);
      chk($sformatf("v%0d kbdr", i), kbdr[sel], tbl[i].kd);
      chk($sformatf("v%0d dv_count", i), 16'(dvcnt), 16'(tbl[i].dv));
      chk($sformatf("v%0d int", i), {15'b0, kint[sel]}, {15'b0, tbl[i].it});
      if (i == 11) chk("int_lag", 16'(int_cyc - rdy_cyc), 16'd1);
    end
    dvcnt = 0;
    rxl[1] = 1'b0;
    tick(5);
    rxl[1] = 1'b1;
    tick(40);
    chk("glitch kbsr", kbsr[1], 16'h0000);
    chk("glitch kbdr", kbdr[1], 16'h000D);
    chk("glitch dv_count", 16'(dvcnt), 16'd0);
    send(8'h3C, 1'b1, -1);
    tick(2);
    chk("after_glitch kbdr", kbdr[1], 16'h003C);
    chk("after_glitch dv_count", 16'(dvcnt), 16'd1);
    do_read();
    dvcnt = 0;
    rxl[1] = 1'b0;
    tick(256);
    rxl[1] = 1'b1;
    tick(200);
    chk("break kbsr", kbsr[1], 16'h2000);
    chk("break kbdr", kbdr[1], 16'h003C);
    chk("break dv_count", 16'(dvcnt), 16'd0);
    send(8'h7E, 1'b1, -1);
    tick(2);
    chk("after_break kbsr", kbsr[1], 16'hA000);
    chk("after_break kbdr", kbdr[1], 16'h007E);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 5 * cpb(s) + cpb(s) / 2; n++) begin
        rxl[s] = n < cpb(s) ? 1'b0 : 1'b1;
        tick(1);
      end
      rst_n = 1'b0;
      rxl[s] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      chk($sformatf("midrst%0d kbsr", s), kbsr[s], 16'h0000);
      send(8'hA5, 1'b1, -1);
      tick(2);
      chk($sformatf("midrst%0d kbdr", s), kbdr[s], 16'h00A5);
      chk($sformatf("midrst%0d after kbsr", s), kbsr[s], 16'h8000);
      chk($sformatf("midrst%0d dv_count", s), 16'(dvcnt), 16'd1);
    end
    sel = 1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    {m_rdy, m_ie, m_fe, m_ovr, m_kbdr} = '0;
    for (int it = 0; it < 24; it++) begin
      int op, edv, rdc;
      logic [7:0] b;
      logic stop;
      logic [15:0] w;
      op = $urandom_range(0, 3);
      edv = 0;
      dvcnt = 0;
      if (op < 2) begin
        b = 8'($urandom);
        stop = ($urandom_range(0, 4) != 0);
        rdc = (stop && m_rdy && !m_fe && !m_ovr && $urandom_range(0, 1) == 1) ? cleanup_cyc() : -1;
        if (!stop) m_fe = 1'b1;
        else if (!m_rdy || rdc >= 0) begin
          m_kbdr = b;
          m_rdy = 1'b1;
          edv = 1;
        end else m_ovr = 1'b1;
        send(b, stop, rdc);
      end else if (op == 2) begin
        {m_rdy, m_fe, m_ovr} = '0;
        do_read();
      end else begin
        w = 16'($urandom);
        m_ie = w[14];
        do_write(w);
      end
      tick(2);
      chk($sformatf("rnd%0d kbsr", it), kbsr[1], {m_rdy, m_ie, m_fe, m_ovr, 12'h000});
      chk($sformatf("rnd%0d kbdr", it), kbdr[1], {8'h00, m_kbdr});
      chk($sformatf("rnd%0d int", it), {15'b0, kint[1]}, {15'b0, m_rdy & m_ie});
      chk($sformatf("rnd%0d dv_count", it), 16'(dvcnt), 16'(edv));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
